// File: rtl/cpu_step_controller.sv
// Clock-enable sequencer for the single-cycle CPU: debounced single-step, divided free-run, step counter.
// Optional feature macro: BREAKPOINT_EN (halts free-run when PC matches BreakAddr while BreakArm is set).
module cpu_step_controller #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned RUN_DIV   = 50000000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PushButton,
  input  logic             RunMode,
  input  logic [31:0]      PC,
  input  logic [31:0]      BreakAddr,
  input  logic             BreakArm,
  output logic             stepEn,
  output logic             running,
  output logic             halted,
  output logic             btnDb,
  output logic [CNT_W-1:0] stepCount
);

  localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    WAIT_REL,
    RUN,
    HALTED
  } stateT;

  stateT            state;
  logic             btnMeta;
  logic             btnS;
  logic             runMeta;
  logic             runS;
  logic [DB_W-1:0]  dbCnt;
  logic             btnDbQ;
  logic             btnRise;
  logic [DIV_W-1:0] divCnt;
  logic             divTc;

  assign divTc = (divCnt == DIV_W'(RUN_DIV - 1));

`ifndef BREAKPOINT_EN
  logic unusedBreakInputs;
  assign unusedBreakInputs = ^{PC, BreakAddr, BreakArm};
  assign halted            = 1'b0;
`endif

  // Two-flop synchronizers for the raw board inputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      btnMeta <= 1'b0;
      btnS    <= 1'b0;
      runMeta <= 1'b0;
      runS    <= 1'b0;
    end else begin
      btnMeta <= PushButton;
      btnS    <= btnMeta;
      runMeta <= RunMode;
      runS    <= runMeta;
    end
  end

  // Debounce: the level only follows btnS after DB_CYCLES consecutive disagreeing clocks
  always_ff @(posedge clk) begin
    if (!reset) begin
      dbCnt   <= '0;
      btnDb   <= 1'b0;
      btnDbQ  <= 1'b0;
      btnRise <= 1'b0;
    end else begin
      btnDbQ  <= btnDb;
      btnRise <= btnDb & ~btnDbQ;
      if (btnS == btnDb) begin
        dbCnt <= '0;
      end else if (dbCnt == DB_W'(DB_CYCLES - 1)) begin
        btnDb <= btnS;
        dbCnt <= '0;
      end else begin
        dbCnt <= dbCnt + DB_W'(1);
      end
    end
  end

  // Step/run sequencer; stepCount advances on the same edge that raises stepEn
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      stepEn    <= 1'b0;
      running   <= 1'b0;
      divCnt    <= '0;
      stepCount <= '0;
`ifdef BREAKPOINT_EN
      halted    <= 1'b0;
`endif
    end else begin
      stepEn <= 1'b0;
      case (state)
        IDLE: begin
          if (runS) begin
            state   <= RUN;
            running <= 1'b1;
            divCnt  <= '0;
          end else if (btnRise) begin
            state     <= STEP;
            stepEn    <= 1'b1;
            stepCount <= stepCount + CNT_W'(1);
          end
        end
        STEP: begin
          state <= WAIT_REL;
        end
        WAIT_REL: begin
          if (runS) begin
            state   <= RUN;
            running <= 1'b1;
            divCnt  <= '0;
          end else if (!btnDb) begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (!runS) begin
            state   <= IDLE;
            running <= 1'b0;
            divCnt  <= '0;
          end else if (divTc) begin
            divCnt <= '0;
`ifdef BREAKPOINT_EN
            if (BreakArm && (PC == BreakAddr)) begin
              state   <= HALTED;
              running <= 1'b0;
              halted  <= 1'b1;
            end else
`endif
            begin
              stepEn    <= 1'b1;
              stepCount <= stepCount + CNT_W'(1);
            end
          end else begin
            divCnt <= divCnt + DIV_W'(1);
          end
        end
`ifdef BREAKPOINT_EN
        HALTED: begin
          if (!runS) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Self-checking bench for cpu_step_controller: per-cycle reference model plus directed timing checks.
`timescale 1ns/1ps
module tb_cpu_step_controller;

  localparam int unsigned DB  = 4;
  localparam int unsigned DIV = 8;
  localparam int unsigned CW  = 4;

  localparam int M_IDLE   = 0;
  localparam int M_MANUAL = 1;
  localparam int M_RUN    = 2;
  localparam int M_HALT   = 3;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          PushButton = 1'b0;
  logic          RunMode    = 1'b0;
  logic          BreakArm   = 1'b0;
  logic [31:0]   PC         = '0;
  logic [31:0]   BreakAddr  = '0;
  logic          stepEn;
  logic          running;
  logic          halted;
  logic          btnDb;
  logic [CW-1:0] stepCount;

  cpu_step_controller #(
    .DB_CYCLES(DB),
    .RUN_DIV  (DIV),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PushButton(PushButton),
    .RunMode   (RunMode),
    .PC        (PC),
    .BreakAddr (BreakAddr),
    .BreakArm  (BreakArm),
    .stepEn    (stepEn),
    .running   (running),
    .halted    (halted),
    .btnDb     (btnDb),
    .stepCount (stepCount)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  bit chkOn       = 0;

  // Reference model state, advanced once per rising edge
  bit rawBtn[$];
  bit rawRun[$];
  bit mDb         = 0;
  int mDisagree   = 0;
  int mRiseEdge   = -100;
  int mStepEdge   = -100;
  int mMode       = M_IDLE;
  int mRunStart   = 0;
  int mCount      = 0;
  bit mStep       = 0;

  // Event recorder for directed latency checks
  int nPulses      = 0;
  int firstStepCyc = -1;
  int dbRiseCyc    = -1;
  int dbFallCyc    = -1;
  bit prevDb       = 0;

  task automatic cmp(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelEdge(input int n);
    bit sBtn;
    bit sRun;
    bit dbOld;
    bit bp;
    if (!reset) begin
      rawBtn.delete();
      rawRun.delete();
      mDb       = 0;
      mDisagree = 0;
      mRiseEdge = -100;
      mStepEdge = -100;
      mMode     = M_IDLE;
      mCount    = 0;
      mStep     = 0;
      return;
    end
    // What the logic sees this edge is the raw level from two edges ago
    sBtn = (rawBtn.size() >= 2) ? rawBtn[rawBtn.size() - 2] : 1'b0;
    sRun = (rawRun.size() >= 2) ? rawRun[rawRun.size() - 2] : 1'b0;
    rawBtn.push_back(PushButton);
    rawRun.push_back(RunMode);
    dbOld = mDb;
    mStep = 0;
    bp    = 0;
`ifdef BREAKPOINT_EN
    bp = BreakArm && (PC == BreakAddr);
`endif
    case (mMode)
      M_IDLE: begin
        if (sRun) begin
          mMode     = M_RUN;
          mRunStart = n;
        end else if (n == mRiseEdge + 2) begin
          mMode     = M_MANUAL;
          mStep     = 1;
          mStepEdge = n;
        end
      end
      M_MANUAL: begin
        if (n != mStepEdge + 1) begin
          if (sRun) begin
            mMode     = M_RUN;
            mRunStart = n;
          end else if (!dbOld) begin
            mMode = M_IDLE;
          end
        end
      end
      M_RUN: begin
        if (!sRun) mMode = M_IDLE;
        else if ((n - mRunStart) % int'(DIV) == 0) begin
          if (bp) mMode = M_HALT;
          else    mStep = 1;
        end
      end
      default: begin
        if (!sRun) mMode = M_IDLE;
      end
    endcase
    if (mStep) mCount = (mCount + 1) % (1 << CW);
    if (sBtn != mDb) mDisagree++;
    else             mDisagree = 0;
    if (mDisagree == int'(DB)) begin
      mDb       = sBtn;
      mDisagree = 0;
      if (mDb) mRiseEdge = n;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    modelEdge(cyc);
  end

  always @(negedge clk) begin
    if (chkOn) begin
      cmp("stepEn", stepEn, mStep);
      cmp("running", running, (mMode == M_RUN) ? 1 : 0);
      cmp("halted", halted, (mMode == M_HALT) ? 1 : 0);
      cmp("btnDb", btnDb, mDb);
      cmp("stepCount", stepCount, mCount);
    end
    if (stepEn === 1'b1) begin
      nPulses++;
      if (firstStepCyc < 0) firstStepCyc = cyc;
    end
    if (btnDb === 1'b1 && !prevDb) dbRiseCyc = cyc;
    if (btnDb === 1'b0 && prevDb)  dbFallCyc = cyc;
    prevDb = (btnDb === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    reset      = 1'b0;
    RunMode    = 1'b0;
    PushButton = 1'b0;
    BreakArm   = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
    nPulses      = 0;
    firstStepCyc = -1;
    dbRiseCyc    = -1;
    dbFallCyc    = -1;
  endtask

  initial begin
    int t0;
    bit bounce[5];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    tick(3);
    chkOn = 1;
    cmp("rst_stepEn", stepEn, 0);
    cmp("rst_running", running, 0);
    cmp("rst_halted", halted, 0);
    cmp("rst_btnDb", btnDb, 0);
    cmp("rst_stepCount", stepCount, 0);

    // Clean press held 20 clocks, then released
    doReset();
    PushButton = 1'b1;
    t0 = cyc;
    tick(20);
    cmp("clean_pulses", nPulses, 1);
    cmp("clean_step_latency", firstStepCyc - t0, 8);
    cmp("clean_db_rise", dbRiseCyc - t0, 6);
    PushButton = 1'b0;
    t0 = cyc;
    tick(10);
    cmp("clean_db_fall", dbFallCyc - t0, 6);
    cmp("clean_count", stepCount, 1);
    cmp("clean_no_extra", nPulses, 1);

    // Bouncy press, last edge of the bounce starts the stable interval
    doReset();
    t0 = cyc;
    foreach (bounce[i]) begin
      PushButton = bounce[i];
      tick(1);
    end
    tick(16);
    cmp("bounce_pulses", nPulses, 1);
    cmp("bounce_latency", firstStepCyc - t0, 12);
    cmp("bounce_count", stepCount, 1);
    PushButton = 1'b0;
    tick(12);

    // Free-run with a toggling button; counter wraps past 15
    doReset();
    t0 = cyc;
    RunMode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (i % 5 == 0) PushButton = ~PushButton;
      tick(1);
    end
    cmp("run_first_pulse", firstStepCyc - t0, 11);
    cmp("run_pulses", nPulses, 18);
    cmp("run_running", running, 1);
    PushButton = 1'b0;
    tick(10);
    RunMode = 1'b0;
    tick(4);
    cmp("run_stop_pulses", nPulses, 19);
    cmp("run_count_wrap", stepCount, 3);
    cmp("run_stop_running", running, 0);
    tick(30);
    cmp("idle_no_pulse", nPulses, 19);

    // RunMode and button together: no manual step; reset mid-run
    doReset();
    t0 = cyc;
    RunMode    = 1'b1;
    PushButton = 1'b1;
    tick(20);
    cmp("together_first_pulse", firstStepCyc - t0, 11);
    cmp("together_pulses", nPulses, 2);
    reset = 1'b0;
    tick(1);
    cmp("midrst_running", running, 0);
    cmp("midrst_stepEn", stepEn, 0);
    cmp("midrst_btnDb", btnDb, 0);
    cmp("midrst_count", stepCount, 0);
    RunMode    = 1'b0;
    PushButton = 1'b0;
    reset      = 1'b1;
    tick(10);

    // Breakpoint stimulus
    doReset();
    BreakArm  = 1'b1;
    BreakAddr = 32'h0000_000C;
    PC        = 32'h0000_000C;
    RunMode   = 1'b1;
    tick(30);
`ifdef BREAKPOINT_EN
    cmp("bp_pulses", nPulses, 0);
    cmp("bp_halted", halted, 1);
    cmp("bp_count", stepCount, 0);
`else
    cmp("bp_pulses", nPulses, 3);
    cmp("bp_halted", halted, 0);
    cmp("bp_count", stepCount, 3);
`endif
    RunMode = 1'b0;
    tick(5);
    cmp("bp_leave_halted", halted, 0);
    cmp("bp_leave_running", running, 0);
    PushButton = 1'b1;
    tick(12);
    PushButton = 1'b0;
    tick(10);
`ifdef BREAKPOINT_EN
    cmp("bp_manual_count", stepCount, 1);
`else
    cmp("bp_manual_count", stepCount, 4);
`endif
    BreakArm = 1'b0;
    RunMode  = 1'b1;
    tick(22);
    cmp("bp_resume_running", running, 1);
`ifdef BREAKPOINT_EN
    cmp("bp_resume_count", stepCount, 3);
`else
    cmp("bp_resume_count", stepCount, 6);
`endif
    RunMode = 1'b0;
    tick(5);

    chkOn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
